fc_pe_arr_gen: RTL and testbench
================================

FC_PE_ARR_GEN -- requirements
Module: fc_pe_arr_gen

Interface
REQ-001 SHALL have parameter N_PE, default 64, number of PE columns (>=2).
REQ-002 SHALL have parameter X_W, default 9, signed activation width.
REQ-003 SHALL have parameter W_W, default 9, signed weight width.
REQ-004 SHALL have parameter ACC_W, default 32, signed accumulator width (>= X_W+W_W).
REQ-005 SHALL have port clk  in  1  single clock, all logic rising-edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port mat_vld  in  1  input beat valid; beats with mat_vld=0 are bubbles.
REQ-008 SHALL have port mat_x  in  X_W  activation broadcast to all columns.
REQ-009 SHALL have port mat_w  in  N_PE*X_W... correction: N_PE*W_W  weights, column i at [i*W_W+:W_W].
REQ-010 SHALL have port mat_begin  in  1  first beat of an accumulation group.
REQ-011 SHALL have port mat_end  in  1  final beat of a group.
REQ-012 SHALL have port mat_end_last  in  1  final group of the layer; qualified by mat_end.
REQ-013 SHALL have port mat_y  out  N_PE*ACC_W  column results, column i at [i*ACC_W+:ACC_W].
REQ-014 SHALL have port mat_y_vld  out  1  one-cycle pulse, mat_y valid.
REQ-015 SHALL have port mat_y_last  out  1  with mat_y_vld, result of the mat_end_last group.
REQ-016 SHALL have port mat_y_ovf  out  1  with mat_y_vld, any column saturated in that group.

Function
REQ-017 SHALL act on a beat only when mat_vld=1; begin/end/last/x/w on bubble beats are ignored, and accumulators hold.
REQ-018 SHALL, per column i, on accepted beat: acc = x*w if begin, else acc + x*w; products sign-extended to ACC_W.
REQ-019 SHALL treat begin=end=1 in one beat as a one-beat group (result = x*w).
REQ-020 SHALL treat end without a preceding begin as continuing the current accumulation.
REQ-021 SHALL ignore mat_end_last when mat_end=0.
REQ-022 SHALL skew the systolic chain so column i processes a beat i cycles after column 0; x, begin, end, vld travel PE to PE, each weight column delayed i cycles.
REQ-023 SHALL capture each column's final sum into a per-column result register on end, so back-to-back groups (end at beat k, begin at beat k+1) lose nothing.
REQ-024 SHALL deskew outputs so all N_PE columns of one group appear in the same cycle.
REQ-025 SHALL assert mat_y_vld exactly N_PE+3 cycles after the edge sampling the accepted end beat, independent of bubbles after that beat.
REQ-026 SHALL hold mat_y stable between pulses; mat_y_last, mat_y_ovf SHALL be 0 when mat_y_vld=0.
REQ-027 SHALL accept a new beat every cycle (no backpressure); full throughput at mat_vld=1 continuously.

Reset
REQ-028 SHALL, on rst=1, clear all accumulators, result registers and pipeline valid/flag stages to 0; mat_y=0, mat_y_vld=0, mat_y_last=0, mat_y_ovf=0 the cycle after.
REQ-029 SHALL discard in-flight groups on reset mid-operation; no mat_y_vld pulse for beats accepted before or during reset.
REQ-030 SHALL ignore inputs while rst=1.

Configuration
REQ-031 SHALL honour macro FC_PE_SAT_EN: defined -> each accumulate clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and sets a per-column sticky flag (cleared at begin) ORed into mat_y_ovf.
REQ-032 SHALL, without FC_PE_SAT_EN, wrap accumulation modulo 2^ACC_W and tie mat_y_ovf to 0, with no saturation logic synthesised.

Verification (N_PE=4, X_W=W_W=9, ACC_W=32)
REQ-033 SHALL cover: 3-beat group x=2,3,4, w all columns=1,2,3,4 -> mat_y={36,27,18,9} (col3..col0), vld at end-edge+7, last per input.
REQ-034 SHALL cover: same group with bubble between each beat -> identical mat_y, vld at 7 cycles after end beat.
REQ-035 SHALL cover: back-to-back one-beat groups x=-256,w=255 then x=5,w=-1 -> consecutive pulses -65280 then -5 per column.
REQ-036 SHALL cover: ACC_W=18, 3 beats x=255,w=255 -> with FC_PE_SAT_EN 131071 and ovf=1; without, wrapped 195075 mod 2^18 as signed (-67069), ovf=0.
REQ-037 SHALL cover: rst asserted 2 cycles after an end beat -> no mat_y_vld pulse, all outputs 0; next group after reset correct.
REQ-038 SHALL cover: mat_end_last=1 with mat_end=0 then group end with last=0 -> mat_y_last stays 0.

Source files
------------

// File: rtl/fc_pe_arr_gen.sv
// fc_pe_arr_gen: skewed systolic row of N_PE multiply-accumulate columns.
// One activation per beat is broadcast down the chain. Each column has its own
// weight lane and accumulates x*w over a begin..end group. Column results are
// deskewed so that all columns of a group leave together, N_PE+3 clocks after
// the edge that samples the end beat.
// Optional feature: define FC_PE_SAT_EN for saturating accumulation with a
// per-group overflow flag. When it is undefined, accumulation wraps and
// mat_y_ovf is tied low.
module fc_pe_arr_gen #(
  parameter int N_PE  = 64,
  parameter int X_W   = 9,
  parameter int W_W   = 9,
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mat_vld,
  input  logic [X_W-1:0]          mat_x,
  input  logic [N_PE*W_W-1:0]     mat_w,
  input  logic                    mat_begin,
  input  logic                    mat_end,
  input  logic                    mat_end_last,
  output logic [N_PE*ACC_W-1:0]   mat_y,
  output logic                    mat_y_vld,
  output logic                    mat_y_last,
  output logic                    mat_y_ovf
);

  localparam int P_W = X_W + W_W;

  // Activation and control travel one column per clock.
  logic signed [X_W-1:0] x_p [N_PE];
  logic                  v_p [N_PE];
  logic                  b_p [N_PE];
  logic                  e_p [N_PE];

  // End-of-group event line that times the output pulse.
  logic [N_PE+2:0]       ev_end;
  logic [N_PE+2:0]       ev_last;

  // All column results, deskewed into the same cycle.
  logic [N_PE*ACC_W-1:0] y_al;
`ifdef FC_PE_SAT_EN
  logic [N_PE-1:0]       ovf_al;
`endif

  // Activation/control chain. Element 0 doubles as the input register;
  // bubbles only clear the valid so that downstream state holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_PE; i++) begin
        x_p[i] <= '0;
        v_p[i] <= 1'b0;
        b_p[i] <= 1'b0;
        e_p[i] <= 1'b0;
      end
    end else begin
      x_p[0] <= $signed(mat_x);
      v_p[0] <= mat_vld;
      b_p[0] <= mat_vld & mat_begin;
      e_p[0] <= mat_vld & mat_end;
      for (int i = 1; i < N_PE; i++) begin
        x_p[i] <= x_p[i-1];
        v_p[i] <= v_p[i-1];
        b_p[i] <= b_p[i-1];
        e_p[i] <= e_p[i-1];
      end
    end
  end

  // Event line. The last flag is only honoured together with an accepted end.
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_end  <= '0;
      ev_last <= '0;
    end else begin
      ev_end  <= {ev_end[N_PE+1:0], mat_vld & mat_end};
      ev_last <= {ev_last[N_PE+1:0], mat_vld & mat_end & mat_end_last};
    end
  end

  for (genvar i = 0; i < N_PE; i++) begin : gen_col
    logic signed [W_W-1:0]   wd [0:i];
    logic signed [P_W-1:0]   prod;
    logic                    pv;
    logic                    pb;
    logic                    pe;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] acc_nxt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] res;
    logic [ACC_W-1:0]        dk [0:N_PE-1-i];
`ifdef FC_PE_SAT_EN
    logic [ACC_W:0]          sum;
    logic                    ovf_now;
    logic                    stk;
    logic                    stk_nxt;
    logic                    res_ovf;
    logic                    dko [0:N_PE-1-i];
`endif

    assign prod_ext = ACC_W'(prod);

    // The weight lane is delayed so that it meets its beat's activation.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k <= i; k++) begin
          wd[k] <= '0;
        end
      end else begin
        wd[0] <= $signed(mat_w[i*W_W +: W_W]);
        for (int k = 1; k <= i; k++) begin
          wd[k] <= wd[k-1];
        end
      end
    end

    // Multiply stage. Control is carried along to stay aligned with the product.
    always_ff @(posedge clk) begin
      if (rst) begin
        prod <= '0;
        pv   <= 1'b0;
        pb   <= 1'b0;
        pe   <= 1'b0;
      end else begin
        prod <= P_W'(x_p[i]) * P_W'(wd[i]);
        pv   <= v_p[i];
        pb   <= b_p[i];
        pe   <= e_p[i];
      end
    end

    // Next accumulator value: restart on begin, otherwise add to the running sum.
    always_comb begin
      base    = '0;
      acc_nxt = '0;
`ifdef FC_PE_SAT_EN
      sum     = '0;
      ovf_now = 1'b0;
      stk_nxt = 1'b0;
`endif
      if (pb) begin
        base = '0;
      end else begin
        base = acc;
      end
`ifdef FC_PE_SAT_EN
      sum     = {base[ACC_W-1], base} + {prod_ext[ACC_W-1], prod_ext};
      ovf_now = sum[ACC_W] ^ sum[ACC_W-1];
      if (!ovf_now) begin
        acc_nxt = sum[ACC_W-1:0];
      end else if (sum[ACC_W]) begin
        acc_nxt = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        acc_nxt = {1'b0, {(ACC_W-1){1'b1}}};
      end
      if (pb) begin
        stk_nxt = ovf_now;
      end else begin
        stk_nxt = stk | ovf_now;
      end
`else
      acc_nxt = base + prod_ext;
`endif
    end

    // Accumulator and result capture. Capturing on end frees the accumulator
    // so that a new group can begin on the very next beat.
    always_ff @(posedge clk) begin
      if (rst) begin
        acc     <= '0;
        res     <= '0;
`ifdef FC_PE_SAT_EN
        stk     <= 1'b0;
        res_ovf <= 1'b0;
`endif
      end else if (pv) begin
        acc <= acc_nxt;
`ifdef FC_PE_SAT_EN
        stk <= stk_nxt;
`endif
        if (pe) begin
          res     <= acc_nxt;
`ifdef FC_PE_SAT_EN
          res_ovf <= stk_nxt;
`endif
        end
      end
    end

    // Deskew: later columns finish later, so they get shorter delay lines.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < N_PE - i; k++) begin
          dk[k]  <= '0;
`ifdef FC_PE_SAT_EN
          dko[k] <= 1'b0;
`endif
        end
      end else begin
        dk[0]  <= res;
`ifdef FC_PE_SAT_EN
        dko[0] <= res_ovf;
`endif
        for (int k = 1; k < N_PE - i; k++) begin
          dk[k]  <= dk[k-1];
`ifdef FC_PE_SAT_EN
          dko[k] <= dko[k-1];
`endif
        end
      end
    end

    assign y_al[i*ACC_W +: ACC_W] = dk[N_PE-1-i];
`ifdef FC_PE_SAT_EN
    assign ovf_al[i] = dko[N_PE-1-i];
`endif
  end

  // Output register: mat_y only changes on a pulse, and the flags are qualified.
  always_ff @(posedge clk) begin
    if (rst) begin
      mat_y      <= '0;
      mat_y_vld  <= 1'b0;
      mat_y_last <= 1'b0;
`ifdef FC_PE_SAT_EN
      mat_y_ovf  <= 1'b0;
`endif
    end else begin
      mat_y_vld  <= ev_end[N_PE+2];
      mat_y_last <= ev_end[N_PE+2] & ev_last[N_PE+2];
`ifdef FC_PE_SAT_EN
      mat_y_ovf  <= ev_end[N_PE+2] & (|ovf_al);
`endif
      if (ev_end[N_PE+2]) begin
        mat_y <= y_al;
      end
    end
  end

`ifndef FC_PE_SAT_EN
  assign mat_y_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fc_pe_arr_gen.sv
// Bench for fc_pe_arr_gen. It drives two instances from the same beats: one
// with a 32-bit accumulator and one with an 18-bit accumulator. A beat-level
// model pushes expected group results into a scoreboard, and the monitor pops
// one entry for every output pulse it sees.
module tb_fc_pe_arr_gen;
  localparam int NP  = 4;
  localparam int XW  = 9;
  localparam int WW  = 9;
  localparam int AW  = 32;
  localparam int AS  = 18;
  localparam int LAT = NP + 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              mat_vld, mat_begin, mat_end, mat_end_last;
  logic [XW-1:0]     mat_x;
  logic [NP*WW-1:0]  mat_w;
  logic [NP*AW-1:0]  y32;
  logic              v32, l32, o32;
  logic [NP*AS-1:0]  y18;
  logic              v18, l18, o18;

  fc_pe_arr_gen #(.N_PE(NP), .X_W(XW), .W_W(WW), .ACC_W(AW)) u_dut (
    .clk(clk), .rst(rst), .mat_vld(mat_vld), .mat_x(mat_x), .mat_w(mat_w),
    .mat_begin(mat_begin), .mat_end(mat_end), .mat_end_last(mat_end_last),
    .mat_y(y32), .mat_y_vld(v32), .mat_y_last(l32), .mat_y_ovf(o32));

  fc_pe_arr_gen #(.N_PE(NP), .X_W(XW), .W_W(WW), .ACC_W(AS)) u_dut18 (
    .clk(clk), .rst(rst), .mat_vld(mat_vld), .mat_x(mat_x), .mat_w(mat_w),
    .mat_begin(mat_begin), .mat_end(mat_end), .mat_end_last(mat_end_last),
    .mat_y(y18), .mat_y_vld(v18), .mat_y_last(l18), .mat_y_ovf(o18));

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [NP-1:0][63:0] e32;
    logic [NP-1:0][63:0] e18;
    logic                last;
    logic                o32;
    logic                o18;
    int                  due;
  } exp_t;

  exp_t   sb[$];
  exp_t   ex;
  longint a32[NP];
  longint a18[NP];
  bit     s32[NP];
  bit     s18[NP];

  task automatic chk(input string tag, input longint got, input longint exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrapw(input longint v, input int w);
    longint m;
    m = v & ((64'sd1 <<< w) - 64'sd1);
    if (m >= (64'sd1 <<< (w - 1))) m = m - (64'sd1 <<< w);
    return m;
  endfunction

  function automatic void upd(input longint acc_in, input bit stk_in, input longint p,
                              input bit beg, input int w, output longint acc_o, output bit stk_o);
    longint s;
    bit     o;
`ifdef FC_PE_SAT_EN
    longint mx;
    longint mn;
`endif
    o = 1'b0;
    s = (beg ? 64'sd0 : acc_in) + p;
`ifdef FC_PE_SAT_EN
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (w - 1));
    if (s > mx) begin
      s = mx;
      o = 1'b1;
    end else if (s < mn) begin
      s = mn;
      o = 1'b1;
    end
    stk_o = (beg ? 1'b0 : stk_in) | o;
`else
    s     = wrapw(s, w);
    stk_o = o;
`endif
    acc_o = s;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NP; i++) begin
      a32[i] = 64'sd0;
      a18[i] = 64'sd0;
      s32[i] = 1'b0;
      s18[i] = 1'b0;
    end
  endtask

  // Drive one beat and, if it is accepted, advance the model; end beats are scored.
  task automatic beat(input bit v, input int x, input int w0, input int w1, input int w2,
                      input int w3, input bit b, input bit e, input bit l);
    int   wk[NP];
    exp_t ne;
    wk[0] = w0; wk[1] = w1; wk[2] = w2; wk[3] = w3;
    mat_vld      = v;
    mat_x        = XW'(x);
    mat_w        = {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
    mat_begin    = b;
    mat_end      = e;
    mat_end_last = l;
    @(posedge clk);
    #1;
    if (v && !rst) begin
      for (int i = 0; i < NP; i++) begin
        upd(a32[i], s32[i], longint'(x) * longint'(wk[i]), b, AW, a32[i], s32[i]);
        upd(a18[i], s18[i], longint'(x) * longint'(wk[i]), b, AS, a18[i], s18[i]);
      end
      if (e) begin
        ne.o32 = 1'b0;
        ne.o18 = 1'b0;
        for (int i = 0; i < NP; i++) begin
          ne.e32[i] = a32[i];
          ne.e18[i] = a18[i];
          ne.o32    = ne.o32 | s32[i];
          ne.o18    = ne.o18 | s18[i];
        end
        ne.last = l;
        ne.due  = cyc + LAT;
        sb.push_back(ne);
      end
    end
  endtask

  task automatic bubble();
    beat(1'b0, 99, 7, 7, 7, 7, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic do_reset(input int n);
    rst          = 1'b1;
    mat_vld      = 1'b1;
    mat_begin    = 1'b1;
    mat_end      = 1'b1;
    mat_end_last = 1'b1;
    mat_x        = XW'(3);
    sb.delete();
    clear_model();
    repeat (n) @(posedge clk);
    #1;
    rst     = 1'b0;
    mat_vld = 1'b0;
    chk("rst_y32_zero", longint'(y32 != '0), 0);
    chk("rst_y18_zero", longint'(y18 != '0), 0);
    chk("rst_vld", longint'({v32, v18}), 0);
    chk("rst_last", longint'({l32, l18}), 0);
    chk("rst_ovf", longint'({o32, o18}), 0);
  endtask

  logic [NP*AW-1:0] prev32 = '0;
  logic [NP*AS-1:0] prev18 = '0;

  // Pops one scoreboard entry per pulse; between pulses, checks hold and flag quiet.
  always @(negedge clk) begin
    if (v32 || v18) begin
      tests++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_pulse: observed pulse at cycle %0d expected none", cyc);
      end
      if (sb.size() > 0) begin
        ex = sb.pop_front();
        chk("vld32", longint'(v32), 1);
        chk("vld18", longint'(v18), 1);
        chk("latency", cyc, ex.due);
        chk("last32", longint'(l32), longint'(ex.last));
        chk("last18", longint'(l18), longint'(ex.last));
        chk("ovf32", longint'(o32), longint'(ex.o32));
        chk("ovf18", longint'(o18), longint'(ex.o18));
        for (int i = 0; i < NP; i++) begin
          chk($sformatf("y32_c%0d", i), longint'($signed(y32[i*AW +: AW])), $signed(ex.e32[i]));
          chk($sformatf("y18_c%0d", i), longint'($signed(y18[i*AS +: AS])), $signed(ex.e18[i]));
        end
      end
    end else begin
      chk("idle_flags", longint'({l32, l18, o32, o18}), 0);
      if (!rst_q) begin
        chk("hold32", longint'(y32 !== prev32), 0);
        chk("hold18", longint'(y18 !== prev18), 0);
      end
    end
    prev32 = y32;
    prev18 = y18;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    mat_vld      = 1'b0;
    mat_begin    = 1'b0;
    mat_end      = 1'b0;
    mat_end_last = 1'b0;
    mat_x        = '0;
    mat_w        = '0;
    clear_model();
    do_reset(3);

    // Three-beat group, weights 1..4 per column, flagged last.
    beat(1'b1, 2, 1, 2, 3, 4, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 3, 1, 2, 3, 4, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 4, 1, 2, 3, 4, 1'b0, 1'b1, 1'b1);
    // The same group with bubbles carrying junk control between the beats.
    beat(1'b1, 2, 1, 2, 3, 4, 1'b1, 1'b0, 1'b0);
    bubble();
    beat(1'b1, 3, 1, 2, 3, 4, 1'b0, 1'b0, 1'b0);
    bubble();
    beat(1'b1, 4, 1, 2, 3, 4, 1'b0, 1'b1, 1'b0);
    repeat (3) bubble();
    // Back-to-back one-beat groups, then an end without a begin that continues.
    beat(1'b1, -256, 255, 255, 255, 255, 1'b1, 1'b1, 1'b0);
    beat(1'b1, 5, -1, -1, -1, -1, 1'b1, 1'b1, 1'b1);
    beat(1'b1, 2, 1, 1, 1, 1, 1'b0, 1'b1, 1'b0);
    // Large products: 18-bit build saturates or wraps.
    beat(1'b1, 255, 255, 255, 255, 255, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 255, 255, 255, 255, 255, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 255, 255, 255, 255, 255, 1'b0, 1'b1, 1'b0);
    // Small group afterwards; the sticky flag must clear on begin.
    beat(1'b1, -3, 7, -7, 100, -100, 1'b1, 1'b1, 1'b0);
    repeat (LAT + 2) bubble();

    // Reset two cycles after an end beat discards that group.
    beat(1'b1, 2, 1, 2, 3, 4, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 4, 1, 2, 3, 4, 1'b0, 1'b1, 1'b1);
    bubble();
    do_reset(2);
    repeat (LAT + 2) bubble();
    beat(1'b1, 2, 1, 2, 3, 4, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 3, 1, 2, 3, 4, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 4, 1, 2, 3, 4, 1'b0, 1'b1, 1'b1);

    // Last without end is ignored.
    beat(1'b1, 1, 1, 1, 1, 1, 1'b1, 1'b0, 1'b1);
    beat(1'b1, 1, 1, 1, 1, 1, 1'b0, 1'b1, 1'b0);

    repeat (LAT + 4) bubble();
    chk("drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
